add_multi_accu_seq: RTL and testbench
=====================================

// Module: add_multi_accu_seq
// PURPOSE
//  Streams vectors of N args into one add_multi tree and accumulates BEATS tree sums into one result.
//  It tracks add_multi pipeline latency with a valid/last shift register, since the tree has no valid of its own.
//  Back-pressure freezes the tree through its en input.
//  Sits between an activation/product stream and the MVU output FIFO (long-vector reduction).
// PARAMETERS
//  N          4    args per beat (tree width), >=1
//  ARG_WIDTH  4    bits per arg
//  ARG_LO     0    min arg value; <0 selects signed arithmetic
//  ARG_HI     0    max arg value (0,0 => full ARG_WIDTH range)
//  BEATS      3    beats reduced per output, >=1
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  synchronous, active-high reset
//  s_tdata    in   N*ARG_WIDTH        arg[i] = s_tdata[i*ARG_WIDTH +: ARG_WIDTH]
//  s_tvalid   in   1                  input beat valid
//  s_tready   out  1                  input beat accepted when s_tvalid & s_tready
//  m_tdata    out  ACC_WIDTH          reduced sum, sign-extended if signed
//  m_tvalid   out  1                  result valid
//  m_tready   in   1                  result consumed when m_tvalid & m_tready
// BEHAVIOUR
//  - Clock/reset: one clock clk; rst synchronous, active-high; rst also drives add_multi.rst.
//  - Reset values: m_tvalid=0, m_tdata=0, acc=0, beat counter=0, all pipeline valids=0.
//  - s_tready=0 during rst.
//  - Stall and tree enable: stall = m_tvalid & ~m_tready. en = ~stall & ~rst.
//  - s_tready = en, combinational from m_tvalid/m_tready and never from s_tvalid.
//  - Tree inputs: args feed add_multi directly. Tree latency is L = addtree_latency(N) = max(0, $clog2(N+1)-2).
//  - Valid/last pipeline: vld[L:0]/lst[L:0] shift when en. Stage 0 = s_tvalid & s_tready, last = (cnt==BEATS-1).
//    For L=0 the tree sum and stage 0 are same-cycle.
//  - Beat counter: cnt increments per accepted beat and wraps BEATS-1 -> 0; no tlast input.
//  - Accumulator, on en & vld[L]: acc_next = (first ? 0 : acc) + sext(sum).
//    first is set by reset and after each last beat.
//    If lst[L], then m_tdata <= acc_next, m_tvalid <= 1, acc <= 0, first <= 1; otherwise acc <= acc_next.
//  - Output handshake: m_tvalid clears on m_tready unless a new last beat loads in the same cycle.
//    In that case m_tvalid stays 1 with new data.
//  - Latency: last beat accepted in cycle t => m_tvalid in cycle t+L+1.
//  - Throughput: 1 beat/cycle sustained with m_tready=1, including back-to-back reductions.
//  - Stall: the whole pipeline, acc and cnt freeze. No beat is lost or duplicated.
//    m_tdata is stable while m_tvalid & ~m_tready.
//  - Reset mid-reduction: the partial sum and in-flight beats are discarded; the next accepted beat is beat 0.
//  - BEATS=1: every beat produces a result; acc is unused except as a zero term.
//  - Arithmetic: SIGNED = ARG_LO<0. SUM_WIDTH = sumwidth(N,ARG_WIDTH,ARG_LO,ARG_HI).
//    ACC_WIDTH = sumwidth(N*BEATS,ARG_WIDTH,ARG_LO,ARG_HI). No overflow is possible by construction.
// STRUCTURE
//  - mvu_pkg: add function addtree_latency(N). Reuse sumwidth.
//    ACC_WIDTH is a localparam here, so no new typedefs are needed.
//  - One sub-module: add_multi (N, ARG_WIDTH, ARG_LO, ARG_HI), clocked by clk/rst/en.
//  - Local logic: counter, valid/last shift register, accumulator, output register.
// TESTING (N=4, ARG_WIDTH=4, ARG_LO=-8, ARG_HI=7, BEATS=3, L=1 unless noted)
//  - 3 beats all args=1, m_tready=1 -> m_tdata=12 exactly 2 cycles after the 3rd beat; one m_tvalid pulse.
//  - 3 beats all args=-8 -> m_tdata=-96; args 7 -> 84. Check sign extension across ACC_WIDTH.
//  - 6 back-to-back beats (values 1..6 broadcast to all args), m_tready=1 -> results 24, 60 on consecutive reductions.
//    s_tready stays 1 throughout.
//  - Hold m_tready=0 after the first result -> s_tready drops in the same cycle and m_tdata is held.
//    Release after 5 cycles -> the second result is correct with no lost beats.
//  - Assert rst after 2 beats of a reduction, then send 3 beats of 2 -> m_tdata=24, not polluted by the partial sum.
//  - Sweep N in {1,2,3,8,9}, BEATS in {1,5}, random args and random m_tready -> matches the scoreboard sum.
//    Measured latency equals addtree_latency(N)+1.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared width and latency helpers for the MVU reduction datapath.
// Used at elaboration time only; nothing here becomes logic.
package mvu_pkg;

   // Pipeline depth of an add_multi tree with n inputs.
   function automatic int addtree_latency(input int n);
      int l;
      l = $clog2(n + 1) - 2;
      return (l > 0) ? l : 0;
   endfunction

   // Narrowest width that holds any sum of n args drawn from [arg_lo, arg_hi].
   // (0,0) selects the full unsigned arg_width range. A negative low bound means signed.
   function automatic int sumwidth(input int n, input int arg_width,
                                   input int arg_lo, input int arg_hi);
      longint lo;
      longint hi;
      longint smin;
      longint smax;
      int     w;
      if (arg_lo == 0 && arg_hi == 0) begin
         lo = 0;
         hi = (longint'(1) << arg_width) - 1;
      end else begin
         lo = longint'(arg_lo);
         hi = longint'(arg_hi);
      end
      smin = longint'(n) * lo;
      smax = longint'(n) * hi;
      w    = 1;
      if (lo < 0) begin
         while (w < 63 && ((-(longint'(1) << (w - 1)) > smin) ||
                           (((longint'(1) << (w - 1)) - 1) < smax)))
            w++;
      end else begin
         while (w < 63 && (((longint'(1) << w) - 1) < smax))
            w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/add_multi.sv
// N-input adder with addtree_latency(N) register stages and a global enable.
// It carries no valid of its own; the caller tracks which outputs are meaningful.
module add_multi
   import mvu_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int ARG_WIDTH = 4,
   parameter  int ARG_LO    = 0,
   parameter  int ARG_HI    = 0,
   localparam int SUM_WIDTH = sumwidth(N, ARG_WIDTH, ARG_LO, ARG_HI)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N*ARG_WIDTH-1:0] args,
   output logic [SUM_WIDTH-1:0]   sum
);

   localparam bit SIGNED    = (ARG_LO < 0);
   localparam int L         = addtree_latency(N);
   localparam int EXT_WIDTH = (SUM_WIDTH > ARG_WIDTH) ? SUM_WIDTH : ARG_WIDTH;

   logic [SUM_WIDTH-1:0] sum_comb;

   // NOTE: every variable assigned here gets a value before any branch, so no latch is inferred.
   always_comb begin
      logic [EXT_WIDTH-1:0] total;
      total = '0;
      for (int i = 0; i < N; i++) begin
         if (SIGNED) total = total + EXT_WIDTH'($signed(args[i*ARG_WIDTH +: ARG_WIDTH]));
         else        total = total + EXT_WIDTH'(args[i*ARG_WIDTH +: ARG_WIDTH]);
      end
      // Modular arithmetic: the true sum always fits SUM_WIDTH, so truncation is exact.
      sum_comb = total[SUM_WIDTH-1:0];
   end

   if (L == 0) begin : g_comb
      assign sum = sum_comb;
   end else begin : g_pipe
      // Stages sit after the adder so retiming can pull them into the tree levels.
      logic [SUM_WIDTH-1:0] stage_q [L];

      // NOTE: non-blocking assignment so every stage shifts from its pre-edge neighbour.
      // NOTE: the stages are individual flops rather than a RAM, so they take the reset like any register.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s < L; s++) stage_q[s] <= '0;
         end else if (en) begin
            stage_q[0] <= sum_comb;
            for (int s = 1; s < L; s++) stage_q[s] <= stage_q[s-1];
         end
      end

      assign sum = stage_q[L-1];
   end

endmodule

// File: rtl/add_multi_accu_seq.sv
// Long-vector reduction: one add_multi tree summing N args per beat, accumulated over BEATS beats.
// A valid/last shadow pipeline follows the tree; output back-pressure freezes everything.
module add_multi_accu_seq
   import mvu_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int ARG_WIDTH = 4,
   parameter  int ARG_LO    = 0,
   parameter  int ARG_HI    = 0,
   parameter  int BEATS     = 3,
   localparam int ACC_WIDTH = sumwidth(N * BEATS, ARG_WIDTH, ARG_LO, ARG_HI)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*ARG_WIDTH-1:0] s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   output logic [ACC_WIDTH-1:0]   m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready
);

   localparam bit                    SIGNED    = (ARG_LO < 0);
   localparam int                    L         = addtree_latency(N);
   localparam int                    SUM_WIDTH = sumwidth(N, ARG_WIDTH, ARG_LO, ARG_HI);
   localparam int                    CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(BEATS - 1);

   logic                 stall;
   logic                 en;
   logic                 accept;
   logic [SUM_WIDTH-1:0] sum;
   logic [L:0]           vld;
   logic [L:0]           lst;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] sum_ext;
   logic [ACC_WIDTH-1:0] acc_next;
   logic [ACC_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic                 first_q, first_d;

   // Ready depends only on the output side, never on s_tvalid.
   assign stall    = m_tvalid_q & ~m_tready;
   assign en       = ~stall & ~rst;
   assign s_tready = en;
   assign accept   = s_tvalid & en;

   add_multi #(
      .N         (N),
      .ARG_WIDTH (ARG_WIDTH),
      .ARG_LO    (ARG_LO),
      .ARG_HI    (ARG_HI)
   ) u_tree (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .args (s_tdata),
      .sum  (sum)
   );

   assign vld[0] = accept;
   assign lst[0] = (cnt_q == CNT_LAST);

   if (L > 0) begin : g_track
      logic [L:1] vld_q;
      logic [L:1] lst_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
         end else if (en) begin
            vld_q <= vld[L-1:0];
            lst_q <= lst[L-1:0];
         end
      end

      assign vld[L:1] = vld_q;
      assign lst[L:1] = lst_q;
   end

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      first_d    = first_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;

      if (SIGNED) sum_ext = ACC_WIDTH'($signed(sum));
      else        sum_ext = ACC_WIDTH'(sum);
      acc_next = (first_q ? '0 : acc_q) + sum_ext;

      if (accept) cnt_d = lst[0] ? '0 : cnt_q + CNT_WIDTH'(1);

      if (m_tvalid_q && m_tready) m_tvalid_d = 1'b0;

      // A last beat arriving on a consumed result reloads m_tvalid in the same cycle.
      if (en && vld[L]) begin
         if (lst[L]) begin
            m_tdata_d  = acc_next;
            m_tvalid_d = 1'b1;
            acc_d      = '0;
            first_d    = 1'b1;
         end else begin
            acc_d      = acc_next;
            first_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         first_q    <= 1'b1;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         first_q    <= first_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_add_multi_accu_seq.sv
// Bench for add_multi_accu_seq: directed runs on N=4/BEATS=3 plus a random sweep over N and BEATS.
// Each instance has its own scoreboard of expected reductions and acceptance stamps.
module tb_add_multi_accu_seq;

   localparam int NCFG = 11;

   typedef struct {
      longint val;
      int     stamp;
   } exp_t;

   // Instance table: 0 is the directed config, the rest form the sweep.
   function automatic int cfg_n(input int i);
      case (i)
         0: return 4;
         1, 6: return 1;
         2, 7: return 2;
         3, 8: return 3;
         4, 9: return 8;
         default: return 9;
      endcase
   endfunction

   function automatic int cfg_b(input int i);
      if (i == 0) return 3;
      return (i <= 5) ? 1 : 5;
   endfunction

   // Signed result width for args in [-8,7] summed over N*BEATS terms.
   function automatic int cfg_w(input int i);
      case (i)
         0: return 8;
         1: return 4;
         2: return 5;
         3: return 6;
         4: return 7;
         5: return 8;
         6: return 7;
         7: return 8;
         8: return 8;
         9: return 10;
         default: return 10;
      endcase
   endfunction

   function automatic int cfg_l(input int n);
      case (n)
         4: return 1;
         8, 9: return 2;
         default: return 0;
      endcase
   endfunction

   logic clk;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   event drain_ev;

   logic        d0_rst;
   logic        d0_s_tvalid;
   logic [15:0] d0_s_tdata;
   logic        d0_m_tready;
   logic        d0_s_tready;
   logic        d0_m_tvalid;
   logic [7:0]  d0_m_tdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_h
      localparam int NN = cfg_n(g);
      localparam int BB = cfg_b(g);
      localparam int AW = cfg_w(g);
      localparam int LL = cfg_l(NN);

      logic            rst;
      logic            s_tvalid;
      logic            s_tready;
      logic [NN*4-1:0] s_tdata;
      logic            m_tvalid;
      logic            m_tready;
      logic [AW-1:0]   m_tdata;

      exp_t   sb[$];
      exp_t   e;
      longint part = 0;
      int     beat = 0;
      int     adv = 0;
      bit     prev_vld = 1'b0;
      bit     prev_hs = 1'b0;
      bit     hs;

      add_multi_accu_seq #(
         .N         (NN),
         .ARG_WIDTH (4),
         .ARG_LO    (-8),
         .ARG_HI    (7),
         .BEATS     (BB)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .s_tdata  (s_tdata),
         .s_tvalid (s_tvalid),
         .s_tready (s_tready),
         .m_tdata  (m_tdata),
         .m_tvalid (m_tvalid),
         .m_tready (m_tready)
      );

      if (g == 0) begin : g_dir
         assign rst         = d0_rst;
         assign s_tvalid    = d0_s_tvalid;
         assign s_tdata     = d0_s_tdata;
         assign m_tready    = d0_m_tready;
         assign d0_s_tready = s_tready;
         assign d0_m_tvalid = m_tvalid;
         assign d0_m_tdata  = m_tdata;
      end else begin : g_rnd
         initial begin
            rst      = 1'b1;
            s_tvalid = 1'b0;
            s_tdata  = '0;
            m_tready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            repeat (400) begin
               @(posedge clk);
               #1;
               s_tvalid = ($urandom_range(0, 3) != 0);
               for (int i = 0; i < NN; i++) s_tdata[i*4 +: 4] = 4'($urandom_range(0, 15));
               m_tready = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            m_tready = 1'b1;
         end
      end

      // Sampled on the falling edge, midway between input changes and DUT updates.
      always @(negedge clk) begin
         if (rst) begin
            check($sformatf("c%0d_rst_s_tready", g), s_tready, 0);
            sb.delete();
            part     = 0;
            beat     = 0;
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
         end else begin
            hs = m_tvalid && m_tready;
            // A new result shows up after L+1 non-stalled edges counted from its last beat.
            if (m_tvalid && (!prev_vld || prev_hs)) begin
               if (sb.size() == 0) check($sformatf("c%0d_spurious_vld", g), 1, 0);
               else check($sformatf("c%0d_latency", g), adv - sb[0].stamp, LL + 1);
            end
            if (hs) begin
               if (sb.size() == 0) begin
                  check($sformatf("c%0d_spurious_hs", g), 1, 0);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("c%0d_data", g), longint'($signed(m_tdata)), e.val);
               end
            end
            if (s_tvalid && s_tready) begin
               for (int i = 0; i < NN; i++) part += longint'($signed(s_tdata[i*4 +: 4]));
               beat++;
               if (beat == BB) begin
                  sb.push_back('{val: part, stamp: adv});
                  part = 0;
                  beat = 0;
               end
            end
            if (!(m_tvalid && !m_tready)) adv++;
            prev_vld = m_tvalid;
            prev_hs  = hs;
         end
      end

      initial begin
         @(drain_ev);
         check($sformatf("c%0d_drain", g), sb.size(), 0);
      end
   end

   task automatic beat_in(input logic [3:0] v, input bit must_accept);
      int k;
      @(posedge clk);
      #1;
      d0_s_tvalid = 1'b1;
      d0_s_tdata  = {4{v}};
      @(negedge clk);
      if (must_accept) check("b2b_s_tready", d0_s_tready, 1);
      k = 0;
      while (!d0_s_tready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("beat_accept", d0_s_tready, 1);
   endtask

   task automatic idle();
      @(posedge clk);
      #1 d0_s_tvalid = 1'b0;
   endtask

   // Called right after idle(): the last beat was accepted one cycle earlier.
   task automatic expect_result(input string tag, input longint exp);
      @(negedge clk);
      check({tag, "_early"}, d0_m_tvalid, 0);
      @(negedge clk);
      check({tag, "_vld"}, d0_m_tvalid, 1);
      check({tag, "_data"}, longint'($signed(d0_m_tdata)), exp);
      @(negedge clk);
      check({tag, "_pulse"}, d0_m_tvalid, 0);
   endtask

   initial begin
      d0_rst      = 1'b1;
      d0_s_tvalid = 1'b0;
      d0_s_tdata  = '0;
      d0_m_tready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_s_tready", d0_s_tready, 0);
      @(posedge clk);
      #1 d0_rst = 1'b0;
      @(negedge clk);
      check("rst_m_tvalid", d0_m_tvalid, 0);
      check("rst_m_tdata", d0_m_tdata, 0);
      check("idle_s_tready", d0_s_tready, 1);

      // Basic reduction and sign extension at both range ends.
      repeat (3) beat_in(4'd1, 1'b0);
      idle();
      expect_result("ones", 12);
      repeat (3) beat_in(4'h8, 1'b0);
      idle();
      expect_result("neg", -96);
      repeat (3) beat_in(4'h7, 1'b0);
      idle();
      expect_result("pos", 84);

      // Back-to-back reductions, 1..6 broadcast: results 24 and 60.
      for (int v = 1; v <= 6; v++) beat_in(4'(v), 1'b1);
      idle();
      repeat (5) @(negedge clk);

      // Back-pressure on the first result while the second reduction is in flight.
      @(posedge clk);
      #1 d0_m_tready = 1'b0;
      repeat (3) beat_in(4'd3, 1'b0);
      fork
         begin
            beat_in(4'd5, 1'b0);
            beat_in(4'd6, 1'b0);
            beat_in(4'd7, 1'b0);
            idle();
         end
         begin
            int k;
            k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!d0_m_tvalid && k < 20);
            check("stall_vld", d0_m_tvalid, 1);
            check("stall_s_tready", d0_s_tready, 0);
            repeat (5) begin
               @(negedge clk);
               check("stall_hold_data", longint'($signed(d0_m_tdata)), 36);
               check("stall_hold_ready", d0_s_tready, 0);
            end
            @(posedge clk);
            #1 d0_m_tready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);

      // Reset mid-reduction discards the partial sum.
      beat_in(4'd1, 1'b0);
      beat_in(4'd1, 1'b0);
      idle();
      @(posedge clk);
      #1 d0_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 d0_rst = 1'b0;
      repeat (3) beat_in(4'd2, 1'b0);
      idle();
      expect_result("post_rst", 24);

      wait (cyc >= 700);
      @(negedge clk);
      ->drain_ev;
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
